// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch front end.
// Owns the program counter, drives the instruction ROM request (ce/pc) and
// registers the combinationally returned word into the IF/ID register.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ce,
  output logic [31:0] pc,
  input  logic [31:0] inst_i,
  input  logic        stall_pc,
  input  logic        stall_ifid,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic new_pc_bad;
  logic branch_bad;

  assign new_pc_bad = (new_pc[1:0] != 2'b00);
  assign branch_bad = (branch_target[1:0] != 2'b00);

  // Next-state, next-PC and IF/ID update; flush outranks stall, stall outranks branch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;
    fetch_err_d = fetch_err_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      IDLE: begin
        state_d = RUN;
      end

      RUN: begin
        if (flush) begin
          if_valid_d = 1'b0;
          if_inst_d  = 32'h0;
          if_pc_d    = 32'h0;
          if (new_pc_bad) begin
            state_d     = HALT;
            fetch_err_d = 1'b1;
          end else begin
            pc_d = new_pc;
          end
        end else if (stall_pc) begin
          if (!stall_ifid) begin
            if_valid_d = 1'b0;
            if_inst_d  = 32'h0;
          end
        end else if (branch_flag && branch_bad) begin
          state_d     = HALT;
          fetch_err_d = 1'b1;
          if_valid_d  = 1'b0;
          if_inst_d   = 32'h0;
          if_pc_d     = 32'h0;
        end else begin
          pc_d = branch_flag ? branch_target : (pc_q + 32'd4);
          if (!stall_ifid) begin
            if_inst_d   = inst_i;
            if_pc_d     = pc_q;
            if_valid_d  = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
          end
        end
      end

      HALT: begin
        if (flush && !new_pc_bad) begin
          pc_d        = new_pc;
          fetch_err_d = 1'b0;
          state_d     = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      if_pc_q     <= 32'h0;
      if_inst_q   <= 32'h0;
      if_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      fetch_cnt_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
      fetch_err_q <= fetch_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign ce        = (state_q == RUN);
  assign pc        = pc_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;
  assign fetch_err = fetch_err_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule
